uart_rx_frame: RTL

Oversampling UART frame receiver. It is the receive-side counterpart of `uart_transmitter` and sits between the `BRG` tick and `buffer_rx` in the `uart` top. It synchronises the serial `rx` line and detects start bits on the `s_tick` oversample grid. It samples each bit at mid-bit, checks optional parity and the stop bit, and hands completed bytes to the buffer with a one-cycle strobe plus error status.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_frame_if.sv | 13 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_frame.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the UART receive path.
package uart_pkg;

   localparam int UART_OS   = 16;
   localparam int UART_DBIT = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT
   } rx_state_t;

   // Expected parity bit: even parity is the XOR of the data, odd parity its inverse.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Completion bus from the frame receiver towards the receive buffer.
interface uart_rx_frame_if;

   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       break_det;

   modport master (output rx_data, rx_done, frame_err, parity_err, break_det);
   modport slave  (input  rx_data, rx_done, frame_err, parity_err, break_det);

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start detection, mid-bit sampling,
// optional parity, stop check and a one-cycle completion strobe with flags.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DBIT    = UART_DBIT,
   parameter int OS      = UART_OS,
   parameter int SB_TICK = 16,
   parameter bit PAR_EN  = 1'b0,
   parameter bit PAR_ODD = 1'b0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   uart_rx_frame_if.master bus
);

   localparam int OS_W = $clog2(OS);
   localparam int SB_W = $clog2(SB_TICK);
   localparam int TW   = (SB_W > OS_W) ? SB_W : OS_W;

   localparam logic [TW-1:0] START_LAST = TW'(OS / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST   = TW'(OS - 1);
   localparam logic [TW-1:0] STOP_LAST  = TW'(SB_TICK - 1);
   localparam logic [2:0]    DATA_LAST  = 3'(DBIT - 1);

   rx_state_t     state;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    sh;
   logic [7:0]    sh_shift;
   logic          par_bit;
   logic          par_mis;
   logic          rxs;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (rx),
      .q    (rxs)
   );

   // New bits enter at DBIT-1 so a short frame ends up right-aligned and zero-extended.
   always_comb begin
      sh_shift         = sh >> 1;
      sh_shift[DBIT-1] = rxs;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         tick_cnt       <= '0;
         bit_cnt        <= '0;
         sh             <= '0;
         par_bit        <= 1'b0;
         par_mis        <= 1'b0;
         bus.rx_data    <= '0;
         bus.rx_done    <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.break_det  <= 1'b0;
      end else begin
         bus.rx_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  tick_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (tick_cnt == START_LAST) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     sh       <= sh_shift;
                     if (bit_cnt == DATA_LAST) begin
                        state <= PAR_EN ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (tick_cnt == BIT_LAST) begin
                     tick_cnt <= '0;
                     par_bit  <= rxs;
                     par_mis  <= (rxs != parity_of(sh, PAR_ODD));
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (tick_cnt == STOP_LAST) begin
                     bus.rx_done    <= 1'b1;
                     bus.rx_data    <= sh;
                     bus.frame_err  <= ~rxs;
                     bus.parity_err <= PAR_EN && par_mis;
                     bus.break_det  <= ~rxs && (sh == 8'h00) && (!PAR_EN || !par_bit);
                     state          <= rxs ? IDLE : WAIT;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
            end
            // A line held low after a bad stop bit must go high before a new start is accepted.
            WAIT: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
